// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 raster constants, sync windows and RGB field layout shared by the scan driver.
package vga_timing_pkg;

   localparam int CNT_W     = 16;
   localparam int CLK_DIV   = 4;
   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;

   localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   localparam int R_MSB = 11;
   localparam int R_LSB = 8;
   localparam int G_MSB = 7;
   localparam int G_LSB = 4;
   localparam int B_MSB = 3;
   localparam int B_LSB = 0;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb_t;

   function automatic rgb_t unpack_color(input logic [11:0] c);
      rgb_t v;
      v.r = c[R_MSB:R_LSB];
      v.g = c[G_MSB:G_LSB];
      v.b = c[B_MSB:B_LSB];
      return v;
   endfunction

endpackage

// File: rtl/vga_scan_driver_scan_counter.sv
// scan_counter: modulo-TOTAL counter with enable, terminal-count flag and [WIN_START, WIN_END) window decode.
module scan_counter #(
   parameter int W         = 16,
   parameter int TOTAL     = 800,
   parameter int WIN_START = 656,
   parameter int WIN_END   = 752
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en_i,
   output logic [W-1:0] cnt_o,
   output logic         wrap_o,
   output logic         in_win_o
);

   logic [W-1:0] cnt_q, cnt_d;

   assign wrap_o   = cnt_q == W'(TOTAL - 1);
   assign cnt_d    = !en_i ? cnt_q : wrap_o ? '0 : cnt_q + 1'b1;
   assign in_win_o = cnt_q >= W'(WIN_START) && cnt_q < W'(WIN_END);
   assign cnt_o    = cnt_q;

   always_ff @(posedge clk or negedge reset)
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;

endmodule

// File: rtl/vga_scan_driver.sv
// vga_scan_driver: VGA raster generator; issues pixel coordinates, captures the color reply and drives RGB/sync
// one pixel slot later so video and sync stay aligned.
module vga_scan_driver
   import vga_timing_pkg::*;
#(
   parameter int   CLK_DIV     = vga_timing_pkg::CLK_DIV,
   parameter int   H_VISIBLE   = vga_timing_pkg::H_VISIBLE,
   parameter int   H_FRONT     = vga_timing_pkg::H_FRONT,
   parameter int   H_SYNC      = vga_timing_pkg::H_SYNC,
   parameter int   H_BACK      = vga_timing_pkg::H_BACK,
   parameter int   V_VISIBLE   = vga_timing_pkg::V_VISIBLE,
   parameter int   V_FRONT     = vga_timing_pkg::V_FRONT,
   parameter int   V_SYNC      = vga_timing_pkg::V_SYNC,
   parameter int   V_BACK      = vga_timing_pkg::V_BACK,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [11:0]        color,
   output logic signed [15:0] pix_x,
   output logic signed [15:0] pix_y,
   output logic               visible,
   output logic [3:0]         vga_r,
   output logic [3:0]         vga_g,
   output logic [3:0]         vga_b,
   output logic               hsync,
   output logic               vsync,
   output logic               line_start,
   output logic               frame_start
);

   localparam int HT    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int VT    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DIV_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] h_cnt, v_cnt;
   logic             pix_ce, h_wrap, v_wrap, h_win, v_win;
   rgb_t             rgb_q, rgb_d;
   logic             hs_q, hs_d, vs_q, vs_d, line_q, line_d, frame_q, frame_d;

   assign pix_ce = div_q == DIV_W'(CLK_DIV - 1);
   assign div_d  = pix_ce ? '0 : div_q + 1'b1;

   scan_counter #(
      .W(CNT_W), .TOTAL(HT),
      .WIN_START(H_VISIBLE + H_FRONT), .WIN_END(H_VISIBLE + H_FRONT + H_SYNC)
   ) u_h (
      .clk(clk), .reset(reset), .en_i(pix_ce),
      .cnt_o(h_cnt), .wrap_o(h_wrap), .in_win_o(h_win)
   );

   scan_counter #(
      .W(CNT_W), .TOTAL(VT),
      .WIN_START(V_VISIBLE + V_FRONT), .WIN_END(V_VISIBLE + V_FRONT + V_SYNC)
   ) u_v (
      .clk(clk), .reset(reset), .en_i(pix_ce & h_wrap),
      .cnt_o(v_cnt), .wrap_o(v_wrap), .in_win_o(v_win)
   );

   assign pix_x   = $signed(h_cnt);
   assign pix_y   = $signed(v_cnt);
   assign visible = h_cnt < CNT_W'(H_VISIBLE) && v_cnt < CNT_W'(V_VISIBLE);

   // Blanking is applied at capture, so the registered RGB already carries the delayed visible.
   always_comb begin
      rgb_d   = pix_ce ? (visible ? unpack_color(color) : '0) : rgb_q;
      hs_d    = pix_ce ? (h_win ? SYNC_ACTIVE : ~SYNC_ACTIVE) : hs_q;
      vs_d    = pix_ce ? (v_win ? SYNC_ACTIVE : ~SYNC_ACTIVE) : vs_q;
      line_d  = pix_ce & h_wrap;
      frame_d = pix_ce & h_wrap & v_wrap;
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         div_q   <= '0;
         rgb_q   <= '0;
         hs_q    <= ~SYNC_ACTIVE;
         vs_q    <= ~SYNC_ACTIVE;
         line_q  <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         div_q   <= div_d;
         rgb_q   <= rgb_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         line_q  <= line_d;
         frame_q <= frame_d;
      end

   assign vga_r       = rgb_q.r;
   assign vga_g       = rgb_q.g;
   assign vga_b       = rgb_q.b;
   assign hsync       = hs_q;
   assign vsync       = vs_q;
   assign line_start  = line_q;
   assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_scan_driver.sv
// tb_vga_scan_driver: checks a reduced raster (17x11 slots, 4 clks/slot) against a time-indexed raster model.
module tb_vga_scan_driver;

   localparam int   CD = 4;
   localparam int   HV = 10, HF = 2, HS = 3, HB = 2;
   localparam int   VV = 6, VF = 2, VS = 2, VB = 1;
   localparam int   HT = HV + HF + HS + HB;
   localparam int   VT = VV + VF + VS + VB;
   localparam logic SA = 1'b0;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic [11:0]        color = '0;
   logic signed [15:0] pix_x, pix_y;
   logic               visible, hsync, vsync, line_start, frame_start;
   logic [3:0]         vga_r, vga_g, vga_b;

   int          compared = 0, mismatched = 0;
   int          n = 0;
   bit          const_white = 1'b0;
   logic [11:0] cap = '0;
   int          hs_run = 0, hs_len = 0, vs_run = 0, vs_len = 0;
   int          last_line = -1, line_per = 0, last_frame = -1, frame_per = 0;
   int          line_cnt = 0, lines_per_frame = 0;

   always #5 clk = ~clk;

   always @(posedge clk) n = reset ? n + 1 : 0;

   vga_scan_driver #(
      .CLK_DIV(CD), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_ACTIVE(SA)
   ) dut (
      .clk(clk), .reset(reset), .color(color),
      .pix_x(pix_x), .pix_y(pix_y), .visible(visible),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .hsync(hsync), .vsync(vsync), .line_start(line_start), .frame_start(frame_start)
   );

   function automatic logic [11:0] pattern(input int x, input int y);
      if (x == 3 && y == 2) return 12'hf00;
      return 12'((x * 37 + y * 101 + 5) % 4096);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (n=%0d)", name, act, exp, n);
      end
   endtask

   // One clock: compare against the model at the falling edge, then drive the next color.
   task automatic step();
      int s, x, y, p, px, py;
      logic [11:0] c;
      logic eh, ev, ls;
      @(negedge clk);
      s = n / CD;
      x = s % HT;
      y = (s / HT) % VT;
      c = '0;
      eh = !SA;
      ev = !SA;
      if (s > 0) begin
         p  = s - 1;
         px = p % HT;
         py = (p / HT) % VT;
         c  = (px < HV && py < VV) ? cap : 12'h000;
         eh = (px >= HV + HF && px < HV + HF + HS) ? SA : !SA;
         ev = (py >= VV + VF && py < VV + VF + VS) ? SA : !SA;
      end
      ls = n > 0 && n % CD == 0 && x == 0;
      check("pix_x", 32'(pix_x), 32'(x));
      check("pix_y", 32'(pix_y), 32'(y));
      check("visible", 32'(visible), 32'(x < HV && y < VV));
      check("vga_r", 32'(vga_r), 32'(c[11:8]));
      check("vga_g", 32'(vga_g), 32'(c[7:4]));
      check("vga_b", 32'(vga_b), 32'(c[3:0]));
      check("hsync", 32'(hsync), 32'(eh));
      check("vsync", 32'(vsync), 32'(ev));
      check("line_start", 32'(line_start), 32'(ls));
      check("frame_start", 32'(frame_start), 32'(ls && y == 0));
      if (hsync === SA) hs_run++;
      else begin
         if (hs_run > 0) hs_len = hs_run;
         hs_run = 0;
      end
      if (vsync === SA) vs_run++;
      else begin
         if (vs_run > 0) vs_len = vs_run;
         vs_run = 0;
      end
      if (frame_start === 1'b1) begin
         if (last_frame >= 0) begin
            frame_per = n - last_frame;
            lines_per_frame = line_cnt;
         end
         last_frame = n;
         line_cnt = 0;
      end
      if (line_start === 1'b1) begin
         if (last_line >= 0) line_per = n - last_line;
         last_line = n;
         line_cnt++;
      end
      if (reset && n % CD == CD - 1) begin
         color = const_white ? 12'hfff : pattern(x, y);
         cap = color;
      end else color = const_white ? 12'hfff : 12'($urandom);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_pix_x"}, 32'(pix_x), 0);
      check({tag, "_pix_y"}, 32'(pix_y), 0);
      check({tag, "_visible"}, 32'(visible), 1);
      check({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 0);
      check({tag, "_hsync"}, 32'(hsync), 1);
      check({tag, "_vsync"}, 32'(vsync), 1);
      check({tag, "_strobes"}, 32'({line_start, frame_start}), 0);
   endtask

   initial begin
      repeat (3) step();
      #2 check_reset_values("rst");
      reset = 1'b1;
      repeat (3) step();
      check("first_x_hold", 32'(pix_x), 0);
      step();
      check("first_x_step", 32'(pix_x), 1);
      repeat (1700) begin
         step();
         if (n == 153) begin
            check("dir_r", 32'(vga_r), 32'hf);
            check("dir_g", 32'(vga_g), 0);
            check("dir_b", 32'(vga_b), 0);
         end
      end
      check("hsync_low_clks", hs_len, 12);
      check("vsync_low_clks", vs_len, 136);
      check("line_period", line_per, 68);
      check("frame_period", frame_per, 748);
      check("lines_per_frame", lines_per_frame, 11);
      const_white = 1'b1;
      repeat (800) step();
      const_white = 1'b0;
      for (int i = 0; i < 2000 && !(pix_x == 5 && pix_y == 3); i++) step();
      check("reach_5_3", 32'(pix_x == 5 && pix_y == 3), 1);
      #2 reset = 1'b0;
      #1 check_reset_values("midrst");
      repeat (3) step();
      #2 reset = 1'b1;
      repeat (300) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
